// File: rtl/scs8hd_o2n1a_pipe.sv
// Pipelined multi-lane OR-AND (o211a/o211ai style) with a 2-entry valid/ready
// skid buffer on the result and a saturating hit counter on output transfers.
module scs8hd_o2n1a_pipe #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_OR  = 2,
    parameter int unsigned NUM_AND = 2,
    parameter int unsigned CNT_W   = 8
) (
`ifdef SC_USE_PG_PIN
    input  logic                       vpwr,
    input  logic                       vgnd,
    input  logic                       vpb,
    input  logic                       vnb,
`endif
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [NUM_OR*WIDTH-1:0]    A,
    input  logic [NUM_AND*WIDTH-1:0]   B,
    input  logic                       INV,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [WIDTH-1:0]           X,
    input  logic                       CNT_CLR,
    output logic [CNT_W-1:0]           HIT_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] main_q, main_d;
    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    logic [WIDTH-1:0] lane_res;
    logic             xfer_in;
    logic             xfer_out;
    logic             hit;

    // Per-lane OR of A terms AND-ed with all B terms, optionally inverted.
    always_comb begin
        logic or_t;
        logic and_t;
        lane_res = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            or_t  = 1'b0;
            and_t = 1'b1;
            for (int unsigned j = 0; j < NUM_OR; j++) begin
                or_t = or_t | A[j*WIDTH + i];
            end
            for (int unsigned k = 0; k < NUM_AND; k++) begin
                and_t = and_t & B[k*WIDTH + i];
            end
            lane_res[i] = (or_t & and_t) ^ INV;
        end
    end

    assign xfer_in  = IN_VALID & in_ready_q;
    assign xfer_out = main_vld_q & OUT_READY;
    assign hit      = xfer_out & (|main_q);

    // Skid-buffer steering; main is zeroed whenever it goes empty so X reads 0.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (xfer_out) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_d     = '0;
                skid_vld_d = 1'b0;
            end else if (xfer_in) begin
                main_d     = lane_res;
            end else begin
                main_d     = '0;
                main_vld_d = 1'b0;
            end
        end else if (xfer_in) begin
            if (!main_vld_q) begin
                main_d     = lane_res;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = lane_res;
                skid_vld_d = 1'b1;
            end
        end
        in_ready_d = !skid_vld_d;
    end

    // Clear has priority over a same-cycle hit; count saturates at all ones.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (CNT_CLR) begin
            hit_cnt_d = '0;
        end else if (hit && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
            hit_cnt_q  <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = main_vld_q;
    assign X         = main_q;
    assign HIT_CNT   = hit_cnt_q;

endmodule

// File: doc/scs8hd_o2n1a_pipe.md
Name: scs8hd_o2n1a_pipe

Overview:
- Parametrised, pipelined successor to the single-bit OR-AND cell.
- Per lane it evaluates X = (OR of NUM_OR A-terms) AND (AND of NUM_AND B-terms), with optional runtime output inversion (o211ai-style), across WIDTH lanes.
- Results are registered behind a 2-entry valid/ready skid buffer, so the block can sit in streaming datapaths that need backpressure.
- A saturating hit counter records how many output transfers had any lane asserted.

Parameters:
- WIDTH, 4, number of independent lanes.
- NUM_OR, 2, number of OR-ed terms per lane (>=1).
- NUM_AND, 2, number of AND-ed side terms per lane (>=1); defaults make each lane equal to an o211a.
- CNT_W, 8, hit counter width (>=1).

Ports:
- CLK  input  1  rising-edge clock for all state.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  block can accept a beat; registered.
- A  input  NUM_OR*WIDTH  OR terms; term j of lane i is A[j*WIDTH+i].
- B  input  NUM_AND*WIDTH  AND terms; term k of lane i is B[k*WIDTH+i].
- INV  input  1  invert result of this beat; sampled with the beat.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  downstream accepts beat.
- X  output  WIDTH  lane results of the head beat.
- CNT_CLR  input  1  synchronous clear of HIT_CNT.
- HIT_CNT  output  CNT_W  saturating count of hit transfers.
- vpwr, vgnd, vpb, vnb  input  1 each  present only when SC_USE_PG_PIN is defined; no functional effect in RTL.

Behaviour:
- Lane function: f_i = (|A terms of lane i) & (&B terms of lane i); result_i = f_i ^ INV. Computed combinationally at acceptance and stored, never recomputed later.
- Input transfer: IN_VALID & IN_READY on a rising edge. Output transfer: OUT_VALID & OUT_READY.
- Storage is a main register (drives X/OUT_VALID) plus a skid register.
- IN_READY = !skid_valid, registered.
- Accept, main empty (or main draining this cycle with skid empty): the beat goes to main. OUT_VALID is 1 on the next cycle (latency 1).
- Accept while main is held (OUT_VALID & !OUT_READY): the beat goes to skid, and IN_READY drops on the next cycle.
- Output transfer with skid valid: skid moves to main, skid is emptied, and IN_READY rises on the next cycle.
- Ordering is strictly FIFO. Sustained throughput is 1 beat/cycle when OUT_READY=1. No beat is dropped or duplicated.
- Simultaneous accept and output transfer with skid empty: the new beat replaces main and OUT_VALID stays 1.
- X holds stable while OUT_VALID & !OUT_READY. X is don't-care but driven to 0 when OUT_VALID=0.
- Hit: an output transfer where |X = 1. HIT_CNT increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap).
- CNT_CLR=1 sets HIT_CNT to 0 next cycle. CNT_CLR wins over a same-cycle hit, giving a result of 0.
- Reset (RESET=1 at an edge): OUT_VALID=0, X=0, skid emptied, IN_READY=0 while RESET is high and 1 on the first cycle after release, HIT_CNT=0.
- A beat accepted in the same cycle as RESET is discarded. Reset mid-stream flushes both entries without producing output transfers.
- Inputs are don't-care when IN_VALID=0.

Test Plan:
- Single beat, defaults: A lane0 terms=(0,1), B lane0=(1,1), other lanes zero, INV=0, OUT_READY=1 -> one cycle later OUT_VALID=1, X=4'b0001; HIT_CNT=1 after transfer.
- Inversion: same beat with INV=1 -> X=4'b1110. Beat with all A=0, INV=0 -> X=4'b0000 and HIT_CNT unchanged.
- Backpressure: OUT_READY=0, three consecutive IN_VALID beats -> beats 1-2 accepted, IN_READY=0 from the cycle after beat 2; release OUT_READY -> beats emerge in order 1,2,3 with X unchanged while stalled.
- Streaming: 16 back-to-back beats with OUT_READY=1 -> 16 outputs on 16 consecutive cycles, first at latency 1, IN_READY constant 1.
- Counter: CNT_W=2, 5 hit transfers -> HIT_CNT=3 (saturated). CNT_CLR asserted on the same cycle as a hit -> HIT_CNT=0.
- Reset mid-stream: skid full, RESET pulsed 1 cycle -> OUT_VALID=0, X=0, HIT_CNT=0, IN_READY=1 on the next cycle, no stale beat emitted afterwards.
